reg_pipe: RTL and testbench
===========================

// Module: reg_pipe
// PURPOSE
//  - Parametrised successor of the single general register: a DEPTH-stage chain of DWIDTH-bit
//    registers with valid/ready flow control, bubble collapsing and synchronous flush.
//  - Sits between any producer/consumer pair in the SoC datapath for retiming and elastic buffering.
//  - Driven and checked through the team's register interface; the tester classes are extended for handshake.
// PARAMETERS
//  - DWIDTH  8  data width in bits (>=1)
//  - DEPTH   4  number of register stages (>=1); also the minimum in-to-out latency in cycles
// PORTS
//  - clk        in   1                    clock; all state changes on rising edge
//  - rst_n      in   1                    asynchronous active-low reset
//  - flush      in   1                    synchronous clear of all stages
//  - in_valid   in   1                    producer data valid
//  - in_data    in   DWIDTH               producer data
//  - in_ready   out  1                    pipe can accept in_data this cycle
//  - out_valid  out  1                    last stage holds valid data
//  - out_data   out  DWIDTH               last-stage data
//  - out_ready  in   1                    consumer accepts out_data this cycle
//  - count      out  $clog2(DEPTH+1)      number of occupied stages
// BEHAVIOUR
//  - Reset (rst_n low, async): all stage valid bits and data = 0, so out_valid=0, out_data=0, count=0.
//    in_ready is forced to 0 while rst_n is low and rises combinationally once rst_n is high.
//  - Stage i holds v[i], d[i]; stage DEPTH-1 drives out_valid/out_data directly (registered outputs).
//  - Stage ready: rdy[DEPTH-1] = !v[DEPTH-1] | out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0].
//  - Transfer into stage i when upstream valid & rdy[i]: d[i] <= upstream data, v[i] <= 1.
//    A stage whose data moves on and receives nothing becomes v[i] <= 0; d[i] keeps its old value.
//  - Bubbles collapse: a valid stage advances whenever the next stage is empty, even if out_ready=0.
//  - Handshakes: input accepted on in_valid & in_ready; output consumed on out_valid & out_ready.
//    Once out_valid is asserted, out_data stays stable until consumed (or flush).
//  - Latency: an accepted word reaches out_valid exactly DEPTH cycles later when the pipe is empty.
//    Throughput: 1 word/cycle while out_ready=1.
//  - Full (count==DEPTH) & out_ready=0: in_ready=0, all stages hold.
//    Full & out_ready=1: input accepted in the same cycle (pass-through ready chain, no bubble).
//  - Empty: out_valid=0, count=0, in_ready=1.
//  - count: registered, updated from next-state v[]; never exceeds DEPTH.
//  - flush=1: next cycle all v[]=0 and count=0; the input offered in the flush cycle is dropped.
//    in_ready is still reported in the flush cycle, but the word is discarded. Data registers are not cleared.
//  - flush has priority over all transfers. rst_n low overrides flush and discards all words in flight.
//  - No combinational path from in_* to out_*. There is a combinational path out_ready -> in_ready
//    through the ready chain.
// STRUCTURE
//  - reg_pkg: DEPTH_W = $clog2(DEPTH+1) helper function; shared default constants DWIDTH_DEF=8, DEPTH_DEF=4.
//  - Sub-module reg_pipe_stage #(DWIDTH): one v/d register with up_valid/up_data/dn_ready/flush
//    inputs and v/d/rdy outputs.
//  - reg_pipe: generate-loop of DEPTH reg_pipe_stage instances, plus the count register and in_ready gating.
//  - reg_if is extended with flush/valid/ready/count signals and a modport for the pipe.
// TESTING (DWIDTH=8, DEPTH=4)
//  - Reset mid-stream: rst_n low at any edge -> immediately out_valid=0, count=0, in_ready=0.
//    After release, in_ready=1 and no stale word appears.
//  - Latency: empty pipe, out_ready=1, push 0xA5 at cycle 0 -> out_valid=1 with out_data=0xA5
//    at cycle 4, count=1 in cycles 1..4.
//  - Streaming: push 0x00..0x0F back-to-back, out_ready=1 -> same sequence in order,
//    one word/cycle, in_ready never 0.
//  - Fill/backpressure: out_ready=0, push 0x11,0x22,0x33,0x44 -> count=4, in_ready=0, out_data=0x11 held.
//    Raise out_ready with in_valid=1 (0x55) -> 0x11 consumed and 0x55 accepted in the same cycle; count stays 4.
//  - Bubble collapse: push 0x01, idle 2 cycles, push 0x02, out_ready=0 -> count=2 and no gap.
//    Set out_ready=1 -> 0x01 and 0x02 delivered on consecutive cycles.
//  - Flush: 3 words in flight plus in_valid=1 (0x77) with flush=1 -> next cycle count=0, out_valid=0.
//    0x77 never appears on out_data; the scoreboard error count stays 0.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// Purpose: shared constants and width helper for the elastic register pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   DWIDTH_DEF / DEPTH_DEF : default data width and stage count
//   depth_w()              : width of an occupancy counter able to hold 0..depth
package reg_pipe_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    // Occupancy can range over 0..depth inclusive, hence depth+1 codes.
    function automatic int depth_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// Purpose: handshake bundle between a producer/consumer pair and the register pipe.
// Latency: n/a (wires only).
// Backpressure: out_ready propagates combinationally to in_ready inside the pipe.
//
// Signals:
//   flush                       synchronous clear request
//   in_valid/in_data/in_ready   producer side handshake
//   out_valid/out_data/out_ready consumer side handshake
//   count                       number of occupied stages
// Modports: master = environment driving the pipe, slave = the pipe itself.
interface reg_pipe_if
    import reg_pipe_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
);

    localparam int CW = depth_w(DEPTH);

    logic              flush;
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DWIDTH-1:0] out_data;
    logic              out_ready;
    logic [CW-1:0]     count;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );

endinterface

// File: rtl/reg_pipe_stage.sv
// Purpose: one valid/data register of the elastic pipe.
// Latency: 1 cycle from up_valid/up_data to v/d.
// Backpressure: accepts when empty or when its word leaves this cycle (rdy = !v | dn_ready).
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   flush                drop the held word at the next edge (data register untouched)
//   up_valid, up_data    word offered by the previous stage / producer
//   dn_ready             next stage (or consumer) takes our word this cycle
//   v, d                 registered occupancy and data
//   rdy                  this stage can take up_data this cycle
//   v_nxt                next-state occupancy, used by the parent's occupancy counter
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_valid,
    input  logic [DWIDTH-1:0] up_data,
    input  logic              dn_ready,
    output logic              v,
    output logic [DWIDTH-1:0] d,
    output logic              rdy,
    output logic              v_nxt
);

    logic load;

    assign rdy  = !v || dn_ready;
    assign load = up_valid && rdy;

    // flush wins over any transfer; a word that moves on without a
    // replacement leaves the stage empty.
    always_comb begin
        v_nxt = v;
        if (flush) begin
            v_nxt = 1'b0;
        end else if (load) begin
            v_nxt = 1'b1;
        end else if (dn_ready) begin
            v_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            v <= v_nxt;
            // Data only changes on a real load; emptied stages keep stale data.
            if (!flush && load) begin
                d <= up_data;
            end
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// Purpose: DEPTH-stage elastic register pipe with bubble collapsing and synchronous flush.
// Latency: DEPTH cycles from accepted input to out_valid when empty; 1 word/cycle sustained.
// Backpressure: in_ready = any stage empty or out_ready (combinational out_ready -> in_ready).
//
// Ports:
//   clk, rst_n   clock, async active-low reset (in_ready held low while in reset)
//   bus          reg_pipe_if.slave: flush, in_valid/in_data/in_ready,
//                out_valid/out_data/out_ready, count
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    reg_pipe_if.slave bus
);

    localparam int CW = depth_w(DEPTH);

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  v_nxt;
    logic [DEPTH-1:0]  rdy;
    logic [DEPTH-1:0]  up_v;
    logic [DEPTH-1:0]  dn_rdy;
    logic [DWIDTH-1:0] d    [DEPTH];
    logic [DWIDTH-1:0] up_d [DEPTH];
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_nxt;

    // Ready seen by stage i from everything downstream of it: the consumer
    // is ready, or some later stage is empty so the tail can compact.
    // Built as a running OR from the output end so the chain is a single
    // pass over v[] rather than a feedback through the stage instances.
    always_comb begin
        logic acc;
        acc    = bus.out_ready;
        dn_rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            dn_rdy[i] = acc;
            acc       = acc || !v[i];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign up_v[i] = bus.in_valid;
            assign up_d[i] = bus.in_data;
        end else begin : g_body
            assign up_v[i] = v[i-1];
            assign up_d[i] = d[i-1];
        end

        reg_pipe_stage #(
            .DWIDTH (DWIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (bus.flush),
            .up_valid (up_v[i]),
            .up_data  (up_d[i]),
            .dn_ready (dn_rdy[i]),
            .v        (v[i]),
            .d        (d[i]),
            .rdy      (rdy[i]),
            .v_nxt    (v_nxt[i])
        );

        // A stage's own ready must equal the downstream ready handed to the
        // stage in front of it; this ties the per-stage view to the chain.
        if (i > 0) begin : g_chain_chk
            a_chain : assert property (@(posedge clk) disable iff (!rst_n)
                rdy[i] == dn_rdy[i-1]);
        end
    end

    // Occupancy counter tracks next-state valid bits so it lines up with v[].
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CW'(v_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    assign bus.in_ready  = rst_n && rdy[0];
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign bus.count     = cnt_q;

    a_count_max : assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= CW'(DEPTH));

    a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready && !bus.flush)
        |=> (bus.out_valid && $stable(bus.out_data)));

endmodule

// File: tb/tb_reg_pipe.sv
module tb_reg_pipe;

    localparam int DWIDTH = 8;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst_n;

    reg_pipe_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) bus ();

    reg_pipe #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: ordered list of words in flight (oldest first) with the
    // stage index each currently sits in.
    logic [7:0] mq_d [$];
    int         mq_p [$];
    logic [7:0] rx   [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq_d.delete();
        mq_p.delete();
    endtask

    function automatic bit m_out_valid();
        return (mq_p.size() > 0) && (mq_p[0] == DEPTH - 1);
    endfunction

    // Advance the reference by one clock edge under the given inputs.
    task automatic model_step(input logic fl, input logic iv, input logic [7:0] id, input logic ordy);
        bit acc;
        int lim;
        if (fl) begin
            model_clear();
        end else begin
            acc = iv && ((mq_d.size() < DEPTH) || ordy);
            if (m_out_valid() && ordy) begin
                void'(mq_d.pop_front());
                void'(mq_p.pop_front());
            end
            // Each word moves one stage forward unless it would land on the
            // word ahead of it (after that word has itself moved).
            lim = DEPTH;
            for (int k = 0; k < mq_p.size(); k++) begin
                if (mq_p[k] + 1 < lim) mq_p[k] = mq_p[k] + 1;
                lim = mq_p[k];
            end
            if (acc) begin
                mq_d.push_back(id);
                mq_p.push_back(0);
            end
        end
    endtask

    // One cycle: drive after the falling edge, compare, then step the model
    // for the coming rising edge.
    task automatic cycle(input logic fl, input logic iv, input logic [7:0] id, input logic ordy);
        @(negedge clk);
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        chk("count", 32'(bus.count), 32'(mq_d.size()));
        chk("out_valid", 32'(bus.out_valid), 32'(m_out_valid()));
        if (m_out_valid()) chk("out_data", 32'(bus.out_data), 32'(mq_d[0]));
        chk("in_ready", 32'(bus.in_ready), 32'((mq_d.size() < DEPTH) || ordy));
        if (bus.out_valid && ordy) rx.push_back(bus.out_data);
        model_step(fl, iv, id, ordy);
    endtask

    // Asynchronous reset asserted mid-cycle, away from any edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n77;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("init_out_valid", 32'(bus.out_valid), 32'd0);
        chk("init_count", 32'(bus.count), 32'd0);
        chk("init_in_ready", 32'(bus.in_ready), 32'd0);
        chk("init_out_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Latency through an empty pipe.
        cycle(1'b0, 1'b1, 8'hA5, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            chk("lat_count", 32'(bus.count), 32'd1);
            chk("lat_valid", 32'(bus.out_valid), 32'(c == 4));
        end
        chk("lat_data", 32'(bus.out_data), 32'hA5);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Back-to-back streaming.
        rx.delete();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'(i), 1'b1);
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("stream_len", 32'(rx.size()), 32'd16);
        for (int i = 0; i < rx.size(); i++) chk("stream_order", 32'(rx[i]), 32'(i));

        // Fill under backpressure, then same-cycle consume and accept.
        cycle(1'b0, 1'b1, 8'h11, 1'b0);
        cycle(1'b0, 1'b1, 8'h22, 1'b0);
        cycle(1'b0, 1'b1, 8'h33, 1'b0);
        cycle(1'b0, 1'b1, 8'h44, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fill_out_data", 32'(bus.out_data), 32'h11);
        cycle(1'b0, 1'b1, 8'h55, 1'b1);
        chk("pass_in_ready", 32'(bus.in_ready), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("pass_count", 32'(bus.count), 32'd4);
        chk("pass_out_data", 32'(bus.out_data), 32'h22);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Bubble collapse while stalled.
        cycle(1'b0, 1'b1, 8'h01, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h02, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("bubble_count", 32'(bus.count), 32'd2);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("bubble_first", 32'(bus.out_data), 32'h01);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("bubble_second_vld", 32'(bus.out_valid), 32'd1);
        chk("bubble_second", 32'(bus.out_data), 32'h02);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Flush with words in flight and an input offered in the flush cycle.
        cycle(1'b0, 1'b1, 8'hA1, 1'b0);
        cycle(1'b0, 1'b1, 8'hA2, 1'b0);
        cycle(1'b0, 1'b1, 8'hA3, 1'b0);
        rx.delete();
        cycle(1'b1, 1'b1, 8'h77, 1'b0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n77 = 0;
        foreach (rx[i]) if (rx[i] == 8'h77) n77++;
        chk("flush_no_77", 32'(n77), 32'd0);
        chk("flush_no_words", 32'(rx.size()), 32'd0);

        // Randomised traffic with a mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cycle(($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 3) != 0),
                  8'($urandom),
                  (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
